// File: rtl/squares_om_pkg.sv
// rtl/squares_om_pkg.sv - shared widths, arbiter states and FIFO entry type for the object-memory arbiter
package squares_om_pkg;

    localparam int OM_ADDR_W = 7;
    localparam int OM_DATA_W = 11;
    localparam int OM_DEPTH  = 104;

    typedef enum logic [1:0] {
        GAME      = 2'd0,
        DRAIN     = 2'd1,
        GRANT     = 2'd2,
        NG_ACTIVE = 2'd3
    } om_state_e;

    typedef struct packed {
        logic [OM_ADDR_W-1:0] addr;
        logic [OM_DATA_W-1:0] data;
    } om_entry_t;

    function automatic logic om_addr_in_range(input logic [OM_ADDR_W-1:0] addr);
        return int'(addr) < OM_DEPTH;
    endfunction

endpackage

// File: rtl/object_memory_arbiter_if.sv
// rtl/object_memory_arbiter_if.sv - coordinator, game-logic and object-memory signals (oob_error with OM_BOUNDS_CHECK_EN)
interface object_memory_arbiter_if;

    logic                                  new_game_request;
    logic                                  new_game_in_progress;
    logic                                  resetting;
    logic                                  new_game_ready;
    logic [squares_om_pkg::OM_ADDR_W-1:0]  ng_address;
    logic [squares_om_pkg::OM_DATA_W-1:0]  ng_data;
    logic                                  ng_wren;
    logic [squares_om_pkg::OM_ADDR_W-1:0]  gl_address;
    logic [squares_om_pkg::OM_DATA_W-1:0]  gl_data;
    logic                                  gl_wren;
    logic                                  gl_busy;
    logic                                  gl_ready;
    logic                                  board_valid;
    logic [squares_om_pkg::OM_ADDR_W-1:0]  om_address;
    logic [squares_om_pkg::OM_DATA_W-1:0]  om_data;
    logic                                  om_wren;
`ifdef OM_BOUNDS_CHECK_EN
    logic                                  oob_error;
`endif

    modport slave (
        input  new_game_request, resetting, new_game_ready,
        input  ng_address, ng_data, ng_wren,
        input  gl_address, gl_data, gl_wren, gl_busy,
        output new_game_in_progress, gl_ready, board_valid,
        output om_address, om_data, om_wren
`ifdef OM_BOUNDS_CHECK_EN
        , output oob_error
`endif
    );

    modport master (
        output new_game_request, resetting, new_game_ready,
        output ng_address, ng_data, ng_wren,
        output gl_address, gl_data, gl_wren, gl_busy,
        input  new_game_in_progress, gl_ready, board_valid,
        input  om_address, om_data, om_wren
`ifdef OM_BOUNDS_CHECK_EN
        , input oob_error
`endif
    );

endinterface

// File: rtl/om_write_fifo.sv
// rtl/om_write_fifo.sv - synchronous FIFO buffering game-logic writes (address + data entries)
module om_write_fifo
    import squares_om_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic      clk,
    input  logic      reset_n,
    input  logic      push,
    input  om_entry_t push_entry,
    input  logic      pop,
    output om_entry_t pop_entry,
    output logic      full,
    output logic      empty
);

    localparam int                PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]    FULL_CNT = FIFO_DEPTH[PTR_W:0];

    om_entry_t        mem_q [FIFO_DEPTH];
    om_entry_t        mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);
    assign pop_entry = mem_q[rd_ptr_q];
    // A full FIFO still takes a push when the same cycle frees a slot.
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/object_memory_arbiter.sv
// rtl/object_memory_arbiter.sv - shares the object-memory write port between game logic and the new-game coordinator
// Optional OM_BOUNDS_CHECK_EN: suppress writes at or above OM_DEPTH and raise sticky oob_error.
module object_memory_arbiter
    import squares_om_pkg::*;
#(
    parameter int FIFO_DEPTH    = 4,
    parameter int GRANT_TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    reset_n,
    object_memory_arbiter_if.slave  bus
);

    localparam int               TMR_W    = $clog2(GRANT_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GRANT_TIMEOUT - 1);

    om_state_e            state_q, state_d;
    logic                 pending_q, pending_d;
    logic                 board_valid_q, board_valid_d;
    logic                 ngip_q, ngip_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic [OM_ADDR_W-1:0] om_addr_q, om_addr_d;
    logic [OM_DATA_W-1:0] om_data_q, om_data_d;
    logic                 om_wren_q, om_wren_d;
`ifdef OM_BOUNDS_CHECK_EN
    logic                 oob_q, oob_d;
    logic                 oob_hit;
`endif

    logic                 gl_ready;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    om_entry_t            fifo_head;
    logic                 ng_owns_port;
    logic [OM_ADDR_W-1:0] src_addr;
    logic [OM_DATA_W-1:0] src_data;
    logic                 src_wren;

    om_write_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (fifo_push),
        .push_entry ({bus.gl_address, bus.gl_data}),
        .pop        (fifo_pop),
        .pop_entry  (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= DRAIN;
            pending_q     <= 1'b1;
            board_valid_q <= 1'b0;
            ngip_q        <= 1'b0;
            timer_q       <= '0;
            om_addr_q     <= '0;
            om_data_q     <= '0;
            om_wren_q     <= 1'b0;
`ifdef OM_BOUNDS_CHECK_EN
            oob_q         <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            board_valid_q <= board_valid_d;
            ngip_q        <= ngip_d;
            timer_q       <= timer_d;
            om_addr_q     <= om_addr_d;
            om_data_q     <= om_data_d;
            om_wren_q     <= om_wren_d;
`ifdef OM_BOUNDS_CHECK_EN
            oob_q         <= oob_d;
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        pending_d     = pending_q | bus.new_game_request;
        board_valid_d = board_valid_q;
        ngip_d        = 1'b0;
        timer_d       = timer_q;
        case (state_q)
            GAME: begin
                if (bus.new_game_request || pending_q) begin
                    state_d       = DRAIN;
                    board_valid_d = 1'b0;
                end
            end
            DRAIN: begin
                // The grant absorbs every request seen so far; only a request in the grant cycle survives.
                if (fifo_empty && !bus.gl_busy) begin
                    state_d   = GRANT;
                    ngip_d    = 1'b1;
                    timer_d   = '0;
                    pending_d = bus.new_game_request;
                end
            end
            GRANT: begin
                if (bus.resetting) begin
                    state_d = NG_ACTIVE;
                end else if (timer_q == TMR_LAST) begin
                    ngip_d  = 1'b1;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            NG_ACTIVE: begin
                if (bus.new_game_ready) begin
                    if (pending_q || bus.new_game_request) begin
                        state_d       = DRAIN;
                        board_valid_d = 1'b0;
                    end else begin
                        state_d       = GAME;
                        board_valid_d = 1'b1;
                        pending_d     = 1'b0;
                    end
                end
            end
            default: state_d = DRAIN;
        endcase
    end

    always_comb begin
        ng_owns_port = (state_q == GRANT) || (state_q == NG_ACTIVE);
        gl_ready     = (state_q == GAME) && !fifo_full;
        fifo_push    = bus.gl_wren && gl_ready;
        fifo_pop     = !ng_owns_port && !fifo_empty;
        if (ng_owns_port) begin
            src_addr = bus.ng_address;
            src_data = bus.ng_data;
            src_wren = bus.ng_wren;
        end else begin
            src_addr = fifo_head.addr;
            src_data = fifo_head.data;
            src_wren = fifo_pop;
        end
        om_addr_d = src_addr;
        om_data_d = src_data;
`ifdef OM_BOUNDS_CHECK_EN
        oob_hit   = src_wren && !om_addr_in_range(src_addr);
        om_wren_d = src_wren && !oob_hit;
        oob_d     = oob_q | oob_hit;
`else
        om_wren_d = src_wren;
`endif
    end

    assign bus.new_game_in_progress = ngip_q;
    assign bus.gl_ready             = gl_ready;
    assign bus.board_valid          = board_valid_q;
    assign bus.om_address           = om_addr_q;
    assign bus.om_data              = om_data_q;
    assign bus.om_wren              = om_wren_q;
`ifdef OM_BOUNDS_CHECK_EN
    assign bus.oob_error            = oob_q;
`endif

endmodule

// File: tb/tb_object_memory_arbiter.sv
// tb/tb_object_memory_arbiter.sv - randomized self-checking bench for object_memory_arbiter
module tb_object_memory_arbiter;
    import squares_om_pkg::*;

    localparam int FIFO_DEPTH    = 4;
    localparam int GRANT_TIMEOUT = 255;

    logic      clk = 1'b0;
    logic      reset_n = 1'b0;
    int        n_cmp = 0;
    int        n_err = 0;
    om_entry_t exp_q[$];

    always #5 clk = ~clk;

    object_memory_arbiter_if bus();

    object_memory_arbiter #(.FIFO_DEPTH(FIFO_DEPTH), .GRANT_TIMEOUT(GRANT_TIMEOUT)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.new_game_request = 1'b0;
        bus.resetting        = 1'b0;
        bus.new_game_ready   = 1'b0;
        bus.ng_address       = '0;
        bus.ng_data          = '0;
        bus.ng_wren          = 1'b0;
        bus.gl_address       = '0;
        bus.gl_data          = '0;
        bus.gl_wren          = 1'b0;
        bus.gl_busy          = 1'b0;
    endtask

    // Compares one observed port write against the next expected game write.
    task automatic mon_gl(input string tag);
        om_entry_t e;
        if (bus.om_wren === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL %s unexpected om write addr=%0d data=%0d (required no write)", tag, bus.om_address, bus.om_data);
            end else begin
                e = exp_q.pop_front();
                if ({bus.om_address, bus.om_data} !== e) begin
                    n_err++;
                    $display("FAIL %s om write addr=%0d data=%0d required addr=%0d data=%0d", tag, bus.om_address, bus.om_data, e.addr, e.data);
                end
            end
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 1'b0;
        step();
        step();
        n_cmp++;
        if ({bus.om_address, bus.om_data, bus.om_wren, bus.new_game_in_progress, bus.gl_ready, bus.board_valid} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got addr=%0d data=%0d wren=%b ngip=%b gl_ready=%b bv=%b required all 0",
                     bus.om_address, bus.om_data, bus.om_wren, bus.new_game_in_progress, bus.gl_ready, bus.board_valid);
        end
`ifdef OM_BOUNDS_CHECK_EN
        n_cmp++;
        if (bus.oob_error !== 1'b0) begin n_err++; $display("FAIL reset_oob got %b required 0", bus.oob_error); end
`endif
        reset_n = 1'b1;
        step();
        n_cmp++;
        if (bus.new_game_in_progress !== 1'b1) begin n_err++; $display("FAIL grant_cycle1 ngip got %b required 1", bus.new_game_in_progress); end
        n_cmp++;
        if (bus.gl_ready !== 1'b0) begin n_err++; $display("FAIL grant_gl_ready got %b required 0", bus.gl_ready); end
    endtask

    task automatic test_board_load();
        bus.resetting = 1'b1;
        step();
        n_cmp++;
        if (bus.new_game_in_progress !== 1'b0) begin n_err++; $display("FAIL grant_pulse_width ngip got %b required 0", bus.new_game_in_progress); end
        for (int a = 0; a < OM_DEPTH; a++) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.ng_wren    = 1'b0;
                bus.ng_address = 7'($urandom);
                bus.ng_data    = 11'($urandom);
                step();
                n_cmp++;
                if (bus.om_wren !== 1'b0) begin n_err++; $display("FAIL load_gap wren got %b required 0", bus.om_wren); end
            end
            bus.ng_wren    = 1'b1;
            bus.ng_address = 7'(a);
            bus.ng_data    = 11'(a);
            step();
            n_cmp++;
            if ({bus.om_wren, bus.om_address, bus.om_data} !== {1'b1, 7'(a), 11'(a)}) begin
                n_err++;
                $display("FAIL load_write wren=%b addr=%0d data=%0d required wren=1 addr=%0d data=%0d", bus.om_wren, bus.om_address, bus.om_data, a, a);
            end
        end
        n_cmp++;
        if (bus.board_valid !== 1'b0) begin n_err++; $display("FAIL load_board_valid got %b required 0", bus.board_valid); end
        bus.ng_wren        = 1'b0;
        bus.resetting      = 1'b0;
        bus.new_game_ready = 1'b1;
        step();
        bus.new_game_ready = 1'b0;
        n_cmp++;
        if ({bus.board_valid, bus.gl_ready} !== 2'b11) begin
            n_err++;
            $display("FAIL load_done board_valid=%b gl_ready=%b required 1 1", bus.board_valid, bus.gl_ready);
        end
    endtask

    task automatic test_back_to_back();
        om_entry_t e;
        int        writes = 0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (bus.gl_ready !== 1'b1) begin n_err++; $display("FAIL b2b_gl_ready[%0d] got %b required 1", i, bus.gl_ready); end
            e.addr         = 7'(5 + i);
            e.data         = 11'($urandom);
            bus.gl_address = e.addr;
            bus.gl_data    = e.data;
            bus.gl_wren    = 1'b1;
            exp_q.push_back(e);
            step();
            writes += int'(bus.om_wren);
            mon_gl("b2b");
        end
        bus.gl_wren = 1'b0;
        n_cmp++;
        if (bus.gl_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_after_4 got %b required 1", bus.gl_ready); end
        for (int i = 0; i < 6; i++) begin
            step();
            writes += int'(bus.om_wren);
            mon_gl("b2b");
        end
        n_cmp++;
        if (writes != 4 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL b2b_count wren_cycles=%0d left=%0d required 4 and 0", writes, exp_q.size());
        end
    endtask

    task automatic test_random_game();
        om_entry_t e;
        for (int i = 0; i < 40; i++) begin
            n_cmp++;
            if (bus.gl_ready !== 1'b1) begin n_err++; $display("FAIL rnd_gl_ready got %b required 1", bus.gl_ready); end
            bus.gl_wren    = 1'($urandom);
            e.addr         = 7'($urandom_range(0, OM_DEPTH - 1));
            e.data         = 11'($urandom);
            bus.gl_address = e.addr;
            bus.gl_data    = e.data;
            bus.ng_wren    = 1'($urandom);
            bus.ng_address = 7'($urandom_range(0, OM_DEPTH - 1));
            bus.ng_data    = 11'($urandom);
            if (bus.gl_wren) exp_q.push_back(e);
            step();
            mon_gl("rnd");
        end
        bus.gl_wren = 1'b0;
        bus.ng_wren = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            mon_gl("rnd");
        end
        n_cmp++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL rnd_drained left=%0d required 0", exp_q.size()); end
    endtask

    task automatic test_drain_busy();
        om_entry_t e;
        for (int i = 0; i < 3; i++) begin
            e.addr         = 7'($urandom_range(0, OM_DEPTH - 1));
            e.data         = 11'($urandom);
            bus.gl_address = e.addr;
            bus.gl_data    = e.data;
            bus.gl_wren    = 1'b1;
            exp_q.push_back(e);
            step();
            mon_gl("drain");
        end
        bus.gl_wren          = 1'b0;
        bus.gl_busy          = 1'b1;
        bus.new_game_request = 1'b1;
        step();
        mon_gl("drain");
        bus.new_game_request = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if ({bus.gl_ready, bus.new_game_in_progress} !== 2'b00) begin
                n_err++;
                $display("FAIL drain_hold gl_ready=%b ngip=%b required 0 0", bus.gl_ready, bus.new_game_in_progress);
            end
            bus.gl_wren    = 1'b1;
            bus.gl_address = 7'($urandom_range(0, OM_DEPTH - 1));
            bus.gl_data    = 11'($urandom);
            step();
            mon_gl("drain");
        end
        bus.gl_wren = 1'b0;
        n_cmp++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL drain_empty left=%0d required 0", exp_q.size()); end
        bus.gl_busy = 1'b0;
        step();
        n_cmp++;
        if (bus.new_game_in_progress !== 1'b1) begin n_err++; $display("FAIL drain_grant ngip got %b required 1", bus.new_game_in_progress); end
        n_cmp++;
        if (bus.board_valid !== 1'b0) begin n_err++; $display("FAIL drain_board_valid got %b required 0", bus.board_valid); end
    endtask

    task automatic test_grant_timeout();
        int       cnt = 0;
        logic     w;
        om_entry_t e;
        do begin
            step();
            cnt++;
        end while (bus.new_game_in_progress !== 1'b1 && cnt < 2 * GRANT_TIMEOUT);
        n_cmp++;
        if (cnt != GRANT_TIMEOUT) begin n_err++; $display("FAIL grant_timeout gap=%0d required %0d", cnt, GRANT_TIMEOUT); end
        bus.resetting = 1'b1;
        step();
        for (int i = 0; i < 20; i++) begin
            w                    = 1'($urandom);
            e.addr               = 7'($urandom_range(0, OM_DEPTH - 1));
            e.data               = 11'($urandom);
            bus.ng_wren          = w;
            bus.ng_address       = e.addr;
            bus.ng_data          = e.data;
            bus.new_game_request = (i == 5);
            step();
            n_cmp++;
            if (bus.om_wren !== w || (w && {bus.om_address, bus.om_data} !== e) || bus.new_game_in_progress !== 1'b0) begin
                n_err++;
                $display("FAIL ng_mirror wren=%b addr=%0d data=%0d ngip=%b required wren=%b addr=%0d data=%0d ngip=0",
                         bus.om_wren, bus.om_address, bus.om_data, bus.new_game_in_progress, w, e.addr, e.data);
            end
        end
        bus.new_game_request = 1'b0;
        bus.ng_wren          = 1'b0;
        bus.resetting        = 1'b0;
        bus.new_game_ready   = 1'b1;
        step();
        bus.new_game_ready = 1'b0;
        n_cmp++;
        if ({bus.gl_ready, bus.board_valid, bus.new_game_in_progress} !== 3'b000) begin
            n_err++;
            $display("FAIL requeue_drain gl_ready=%b bv=%b ngip=%b required 0 0 0", bus.gl_ready, bus.board_valid, bus.new_game_in_progress);
        end
        step();
        n_cmp++;
        if (bus.new_game_in_progress !== 1'b1) begin n_err++; $display("FAIL requeue_grant ngip got %b required 1", bus.new_game_in_progress); end
        bus.resetting = 1'b1;
        step();
        bus.resetting      = 1'b0;
        bus.new_game_ready = 1'b1;
        step();
        bus.new_game_ready = 1'b0;
        n_cmp++;
        if ({bus.board_valid, bus.gl_ready} !== 2'b11) begin
            n_err++;
            $display("FAIL requeue_done bv=%b gl_ready=%b required 1 1", bus.board_valid, bus.gl_ready);
        end
    endtask

    task automatic test_async_reset();
        bus.gl_wren    = 1'b1;
        bus.gl_address = 7'($urandom_range(0, OM_DEPTH - 1));
        bus.gl_data    = 11'($urandom);
        step();
        bus.gl_wren = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.om_wren, bus.board_valid, bus.gl_ready} !== 3'b000) begin
            n_err++;
            $display("FAIL async_reset_game wren=%b bv=%b gl_ready=%b required 0 0 0", bus.om_wren, bus.board_valid, bus.gl_ready);
        end
        step();
        reset_n = 1'b1;
        step();
        n_cmp++;
        if ({bus.new_game_in_progress, bus.om_wren} !== 2'b10) begin
            n_err++;
            $display("FAIL fifo_flushed ngip=%b wren=%b required 1 0", bus.new_game_in_progress, bus.om_wren);
        end
        bus.resetting  = 1'b1;
        bus.ng_wren    = 1'b1;
        bus.ng_address = 7'd42;
        bus.ng_data    = 11'd1234;
        step();
        step();
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.om_wren, bus.om_address, bus.om_data} !== '0) begin
            n_err++;
            $display("FAIL async_reset_copy wren=%b addr=%0d data=%0d required 0 0 0", bus.om_wren, bus.om_address, bus.om_data);
        end
        idle_inputs();
        step();
        reset_n = 1'b1;
        step();
        n_cmp++;
        if (bus.new_game_in_progress !== 1'b1) begin n_err++; $display("FAIL reset_regrant ngip got %b required 1", bus.new_game_in_progress); end
        bus.resetting = 1'b1;
        step();
        bus.resetting      = 1'b0;
        bus.new_game_ready = 1'b1;
        step();
        bus.new_game_ready = 1'b0;
        n_cmp++;
        if (bus.board_valid !== 1'b1) begin n_err++; $display("FAIL reset_reload bv got %b required 1", bus.board_valid); end
    endtask

`ifdef OM_BOUNDS_CHECK_EN
    task automatic test_bounds();
        om_entry_t e;
        bus.gl_wren    = 1'b1;
        bus.gl_address = 7'(OM_DEPTH);
        bus.gl_data    = 11'h5a5;
        step();
        bus.gl_wren = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++;
            if (bus.om_wren !== 1'b0) begin n_err++; $display("FAIL oob_suppress wren got %b required 0", bus.om_wren); end
        end
        n_cmp++;
        if (bus.oob_error !== 1'b1) begin n_err++; $display("FAIL oob_set got %b required 1", bus.oob_error); end
        e.addr         = 7'($urandom_range(0, OM_DEPTH - 1));
        e.data         = 11'($urandom);
        bus.gl_address = e.addr;
        bus.gl_data    = e.data;
        bus.gl_wren    = 1'b1;
        exp_q.push_back(e);
        step();
        bus.gl_wren = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            mon_gl("oob_legal");
        end
        n_cmp++;
        if (bus.oob_error !== 1'b1 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL oob_sticky oob=%b left=%0d required 1 and 0", bus.oob_error, exp_q.size());
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_board_load();
        test_back_to_back();
        test_random_game();
        test_drain_busy();
        test_grant_timeout();
        test_async_reset();
`ifdef OM_BOUNDS_CHECK_EN
        test_bounds();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/object_memory_arbiter.md
Name: object_memory_arbiter

Overview:
- Owns the object-memory write port (104 x 11-bit entries, 7-bit address).
- Shares it between game logic (single move writes) and new_game_coordinator (bulk 104-word board load).
- Game writes are buffered in a small FIFO.
- Services the coordinator's new_game_request / new_game_in_progress handshake only after game writes have drained and game logic is idle, then muxes the coordinator onto the port until new_game_ready.

Parameters:
- OM_DEPTH, 104, number of valid object-memory entries (0..103)
- FIFO_DEPTH, 4, game-write buffer entries (power of two, >= 2)
- GRANT_TIMEOUT, 255, cycles to wait for resetting after a grant pulse before re-pulsing

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- new_game_request  in  1  one-cycle request pulse from coordinator
- new_game_in_progress  out  1  one-cycle grant pulse to coordinator
- resetting  in  1  coordinator is copying board (level)
- new_game_ready  in  1  one-cycle copy-complete pulse
- ng_address  in  7  coordinator write address
- ng_data  in  11  coordinator write data
- ng_wren  in  1  coordinator write enable
- gl_address  in  7  game-logic write address
- gl_data  in  11  game-logic write data
- gl_wren  in  1  game-logic write strobe, accepted only when gl_ready=1
- gl_busy  in  1  game logic mid-move, must not be interrupted
- gl_ready  out  1  FIFO can accept a game write this cycle
- board_valid  out  1  object memory holds a complete board
- om_address  out  7  registered write address to object memory
- om_data  out  11  registered write data
- om_wren  out  1  registered write enable

Behaviour:
- Clock and reset: one clock clk; reset_n is asynchronous, active-low.
- Reset values: om_address=0, om_data=0, om_wren=0, new_game_in_progress=0, gl_ready=0, board_valid=0, FIFO empty, state=DRAIN, pending_req=1. Power-up therefore services the coordinator's initial request.
- Port latency: om_* outputs are registered, so an accepted source write appears on om_* exactly one cycle later.

States:
- GAME: gl_ready = ~fifo_full. FIFO pops one entry per cycle to om_*. A simultaneous push and pop on a full FIFO is accepted. On new_game_request (or pending_req): latch pending_req, go to DRAIN.
- DRAIN: gl_ready=0, FIFO keeps popping. When fifo_empty && !gl_busy: pulse new_game_in_progress for 1 cycle, clear the timeout counter, go to GRANT.
- GRANT: om_* driven from ng_*. When resetting=1, go to NG_ACTIVE. If resetting is not seen within GRANT_TIMEOUT cycles, re-pulse the grant and restart the count.
- NG_ACTIVE: om_* driven from ng_* (ng_wren passed through). board_valid=0. On new_game_ready: clear pending_req, set board_valid=1, go to GAME. gl_ready is 1 only in GAME next cycle.

Boundary and conflict rules:
- new_game_request arriving in DRAIN, GRANT or NG_ACTIVE sets pending_req only. No duplicate grant is issued in the same episode.
- A request in the same cycle as new_game_ready re-enters DRAIN on the following cycle.
- gl_wren while gl_ready=0 is dropped.
- ng_wren outside GRANT/NG_ACTIVE is ignored.
- board_valid clears on entry to DRAIN.
- Asynchronous reset mid-copy aborts to DRAIN with FIFO flushed.

Optional Feature:
- OM_BOUNDS_CHECK_EN defined:
  - Writes from either source with address >= OM_DEPTH are suppressed (om_wren stays 0).
  - Sticky output oob_error (1 bit, reset 0) is set.
- OM_BOUNDS_CHECK_EN undefined:
  - Addresses pass through unchecked.
  - No oob_error port.

Decomposition:
- Package squares_om_pkg: OM_ADDR_W=7, OM_DATA_W=11, OM_DEPTH=104, state enum {GAME, DRAIN, GRANT, NG_ACTIVE}, FIFO entry struct {addr, data}.
- Sub-module om_write_fifo:
  - Synchronous FIFO, FIFO_DEPTH x 18 bits.
  - push/pop/full/empty interface.
  - Asynchronous active-low reset.

Test Plan:
- Release reset with gl idle -> new_game_in_progress pulses on cycle 1. Drive resetting=1 and 104 ng writes (addr 0..103, data=addr) -> om_* mirrors each one cycle later. new_game_ready -> board_valid=1, gl_ready=1.
- In GAME, push 4 gl writes back-to-back (addr 5..8) -> gl_ready drops after the 4th only if no pop occurred. om_wren is high 4 cycles with addr 5,6,7,8 in order.
- Push 3 gl writes, hold gl_busy=1, pulse new_game_request -> FIFO drains 3 entries; no grant while gl_busy. Drop gl_busy -> grant pulse next cycle.
- After a grant, keep resetting=0 for GRANT_TIMEOUT+1 cycles -> second new_game_in_progress pulse exactly GRANT_TIMEOUT cycles after the first.
- new_game_request during NG_ACTIVE -> no grant until new_game_ready. Then DRAIN entered the next cycle and a new grant issued.
- With OM_BOUNDS_CHECK_EN: gl write addr 104 -> om_wren stays 0, oob_error=1 and stays set until reset.
